// File: rtl/control_unit.sv
// Moore sequencer for the 8-bit CPU datapath: fetch, decode, and execute of loads,
// stores, ALU ops and branches. Every output is decoded from the current state only.
module control_unit #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001,
  parameter logic [2:0] ALU_AND = 3'b010,
  parameter logic [2:0] ALU_OR  = 3'b011,
  parameter logic [2:0] ALU_INC = 3'b100,
  parameter logic [2:0] ALU_DEC = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic [3:0] ccr_result,
  output logic       ir_load,
  output logic       mar_load,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       a_load,
  output logic       b_load,
  output logic       ccr_load,
  output logic       write,
  output logic [2:0] alu_sel,
  output logic [1:0] bus1_sel,
  output logic [1:0] bus2_sel,
  output logic [4:0] state
);
  localparam logic [7:0] LDA_IMM = 8'h10, LDA_DIR = 8'h11, LDB_IMM = 8'h12, LDB_DIR = 8'h13;
  localparam logic [7:0] STA_DIR = 8'h14, STB_DIR = 8'h15;
  localparam logic [7:0] ADD_AB = 8'h20, SUB_AB = 8'h21, AND_AB = 8'h22, OR_AB = 8'h23;
  localparam logic [7:0] INCA = 8'h24, INCB = 8'h25, DECA = 8'h26, DECB = 8'h27;
  localparam logic [7:0] BRA = 8'h30, BNU = 8'h31, BND = 8'h32, BZU = 8'h33, BZD = 8'h34;
  localparam logic [7:0] BVU = 8'h35, BVD = 8'h36, BCU = 8'h37, BCD = 8'h38;

  localparam logic [4:0] S_F0 = 5'd0, S_F1 = 5'd1, S_F2 = 5'd2, S_D3 = 5'd3;
  localparam logic [4:0] S_OP_E4 = 5'd4, S_OP_E5 = 5'd5;
  localparam logic [4:0] S_LDA_IMM_E6 = 5'd6, S_LDB_IMM_E6 = 5'd7;
  localparam logic [4:0] S_DIR_E6 = 5'd8, S_LD_DIR_E7 = 5'd9;
  localparam logic [4:0] S_LDA_DIR_E8 = 5'd10, S_LDB_DIR_E8 = 5'd11;
  localparam logic [4:0] S_STA_E7 = 5'd12, S_STB_E7 = 5'd13;
  localparam logic [4:0] S_ADD = 5'd14, S_SUB = 5'd15, S_AND = 5'd16, S_OR = 5'd17;
  localparam logic [4:0] S_INCA = 5'd18, S_DECA = 5'd19, S_INCB = 5'd20, S_DECB = 5'd21;
  localparam logic [4:0] S_BR_E4 = 5'd22, S_BR_E5 = 5'd23, S_BR_E6 = 5'd24, S_BR_NT = 5'd25;

  logic [4:0] state_q, state_d;
  logic       n_f, z_f, v_f, c_f, taken;

  assign {n_f, z_f, v_f, c_f} = ccr_result;
  assign state = state_q;

  always_comb begin
    taken = 1'b0;
    case (ir)
      BRA: taken = 1'b1;
      BNU: taken = n_f;
      BND: taken = !n_f;
      BZU: taken = z_f;
      BZD: taken = !z_f;
      BVU: taken = v_f;
      BVD: taken = !v_f;
      BCU: taken = c_f;
      BCD: taken = !c_f;
      default: taken = 1'b0;
    endcase
  end

  // ir is held stable through execute, so shared operand-fetch states fan out on it.
  always_comb begin
    state_d = S_F0;
    case (state_q)
      S_F0: state_d = S_F1;
      S_F1: state_d = S_F2;
      S_F2: state_d = S_D3;
      S_D3:
        case (ir)
          LDA_IMM, LDB_IMM, LDA_DIR, LDB_DIR, STA_DIR, STB_DIR: state_d = S_OP_E4;
          ADD_AB: state_d = S_ADD;
          SUB_AB: state_d = S_SUB;
          AND_AB: state_d = S_AND;
          OR_AB:  state_d = S_OR;
          INCA:   state_d = S_INCA;
          DECA:   state_d = S_DECA;
          INCB:   state_d = S_INCB;
          DECB:   state_d = S_DECB;
          BRA, BNU, BND, BZU, BZD, BVU, BVD, BCU, BCD:
            state_d = taken ? S_BR_E4 : S_BR_NT;
          default: state_d = S_F0;
        endcase
      S_OP_E4: state_d = S_OP_E5;
      S_OP_E5:
        if (ir == LDA_IMM)      state_d = S_LDA_IMM_E6;
        else if (ir == LDB_IMM) state_d = S_LDB_IMM_E6;
        else                    state_d = S_DIR_E6;
      S_DIR_E6:
        if (ir == STA_DIR)      state_d = S_STA_E7;
        else if (ir == STB_DIR) state_d = S_STB_E7;
        else                    state_d = S_LD_DIR_E7;
      S_LD_DIR_E7: state_d = (ir == LDB_DIR) ? S_LDB_DIR_E8 : S_LDA_DIR_E8;
      S_BR_E4: state_d = S_BR_E5;
      S_BR_E5: state_d = S_BR_E6;
      default: state_d = S_F0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_F0;
    else       state_q <= state_d;
  end

  always_comb begin
    ir_load = 1'b0; mar_load = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
    a_load = 1'b0; b_load = 1'b0; ccr_load = 1'b0; write = 1'b0;
    alu_sel = 3'b000; bus1_sel = 2'b00; bus2_sel = 2'b00;
    case (state_q)
      S_F0, S_OP_E4, S_BR_E4: begin bus1_sel = 2'b00; bus2_sel = 2'b01; mar_load = 1'b1; end
      S_F1, S_OP_E5, S_BR_NT: pc_inc = 1'b1;
      S_F2:                   begin bus2_sel = 2'b10; ir_load = 1'b1; end
      S_LDA_IMM_E6, S_LDA_DIR_E8: begin bus2_sel = 2'b10; a_load = 1'b1; end
      S_LDB_IMM_E6, S_LDB_DIR_E8: begin bus2_sel = 2'b10; b_load = 1'b1; end
      S_DIR_E6:               begin bus2_sel = 2'b10; mar_load = 1'b1; end
      S_STA_E7:               begin bus1_sel = 2'b01; write = 1'b1; end
      S_STB_E7:               begin bus1_sel = 2'b10; write = 1'b1; end
      S_ADD:  begin alu_sel = ALU_ADD; bus1_sel = 2'b01; a_load = 1'b1; ccr_load = 1'b1; end
      S_SUB:  begin alu_sel = ALU_SUB; bus1_sel = 2'b01; a_load = 1'b1; ccr_load = 1'b1; end
      S_AND:  begin alu_sel = ALU_AND; bus1_sel = 2'b01; a_load = 1'b1; ccr_load = 1'b1; end
      S_OR:   begin alu_sel = ALU_OR;  bus1_sel = 2'b01; a_load = 1'b1; ccr_load = 1'b1; end
      S_INCA: begin alu_sel = ALU_INC; bus1_sel = 2'b01; a_load = 1'b1; ccr_load = 1'b1; end
      S_DECA: begin alu_sel = ALU_DEC; bus1_sel = 2'b01; a_load = 1'b1; ccr_load = 1'b1; end
      S_INCB: begin alu_sel = ALU_INC; bus1_sel = 2'b10; b_load = 1'b1; ccr_load = 1'b1; end
      S_DECB: begin alu_sel = ALU_DEC; bus1_sel = 2'b10; b_load = 1'b1; ccr_load = 1'b1; end
      S_BR_E6:                begin bus2_sel = 2'b10; pc_load = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction control-word sequences from a vector table,
// checked each cycle through a scoreboard queue, plus reset and CCR-timing sequences.
module tb_control_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] ir = 8'h00;
  logic [3:0] ccr_result = 4'h0;
  logic ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load, write;
  logic [2:0] alu_sel;
  logic [1:0] bus1_sel, bus2_sel;
  logic [4:0] state;

  control_unit dut (
    .clk(clk), .reset(reset), .ir(ir), .ccr_result(ccr_result),
    .ir_load(ir_load), .mar_load(mar_load), .pc_load(pc_load), .pc_inc(pc_inc),
    .a_load(a_load), .b_load(b_load), .ccr_load(ccr_load), .write(write),
    .alu_sel(alu_sel), .bus1_sel(bus1_sel), .bus2_sel(bus2_sel), .state(state)
  );

  always #5 clk = ~clk;

  // {ir_load,mar_load,pc_load,pc_inc,a_load,b_load,ccr_load,write,alu_sel,bus1_sel,bus2_sel}
  localparam logic [14:0] W_MARPC = 15'h2001, W_PCINC = 15'h0800, W_IRLD = 15'h4002;
  localparam logic [14:0] W_NONE = 15'h0000, W_LDA_M = 15'h0402, W_LDB_M = 15'h0202;
  localparam logic [14:0] W_MARMEM = 15'h2002, W_STA = 15'h0084, W_STB = 15'h0088;
  localparam logic [14:0] W_ADD = 15'h0504, W_SUB = 15'h0514, W_AND = 15'h0524, W_OR = 15'h0534;
  localparam logic [14:0] W_INCA = 15'h0544, W_DECA = 15'h0554, W_INCB = 15'h0348, W_DECB = 15'h0358;
  localparam logic [14:0] W_PCLD = 15'h1002;

  typedef struct {
    string       name;
    logic [7:0]  op;
    logic [3:0]  ccr;
    int          ncyc;
    logic [14:0] ex [5];
  } vec_t;

  typedef struct {
    string       tag;
    logic [14:0] word;
  } sb_t;

  sb_t  sb [$];
  vec_t vecs [$];
  int   n_tests = 0, n_fail = 0;

  function automatic vec_t mk(string nm, logic [7:0] op, logic [3:0] ccr, int n,
                              logic [14:0] e0, logic [14:0] e1, logic [14:0] e2,
                              logic [14:0] e3, logic [14:0] e4);
    vec_t v;
    v.name = nm; v.op = op; v.ccr = ccr; v.ncyc = n;
    v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3; v.ex[4] = e4;
    return v;
  endfunction

  task automatic push(string tag, logic [14:0] w);
    sb_t e;
    e.tag = tag; e.word = w;
    sb.push_back(e);
  endtask

  task automatic push_fetch(string nm);
    push({nm, ".F0"}, W_MARPC);
    push({nm, ".F1"}, W_PCINC);
    push({nm, ".F2"}, W_IRLD);
    push({nm, ".D3"}, W_NONE);
  endtask

  // Called one step after the edge that entered F0; leaves the same point for the next one.
  task automatic run_vec(vec_t v);
    ir = v.op; ccr_result = v.ccr;
    push_fetch(v.name);
    for (int k = 0; k < v.ncyc - 4; k++) push($sformatf("%s.E%0d", v.name, k + 4), v.ex[k]);
    repeat (v.ncyc) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      logic [14:0] got;
      e = sb.pop_front();
      got = {ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load, write,
             alu_sel, bus1_sel, bus2_sel};
      n_tests++;
      if (got !== e.word) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (state %0d)", e.tag, got, e.word, state);
      end
    end
  end

  initial begin
    vecs.push_back(mk("lda_imm", 8'h10, 4'h0, 7, W_MARPC, W_PCINC, W_LDA_M, 0, 0));
    vecs.push_back(mk("ldb_imm", 8'h12, 4'hF, 7, W_MARPC, W_PCINC, W_LDB_M, 0, 0));
    vecs.push_back(mk("lda_dir", 8'h11, 4'h0, 9, W_MARPC, W_PCINC, W_MARMEM, W_NONE, W_LDA_M));
    vecs.push_back(mk("ldb_dir", 8'h13, 4'h0, 9, W_MARPC, W_PCINC, W_MARMEM, W_NONE, W_LDB_M));
    vecs.push_back(mk("sta_dir", 8'h14, 4'h0, 8, W_MARPC, W_PCINC, W_MARMEM, W_STA, 0));
    vecs.push_back(mk("stb_dir", 8'h15, 4'h0, 8, W_MARPC, W_PCINC, W_MARMEM, W_STB, 0));
    vecs.push_back(mk("add", 8'h20, 4'h0, 5, W_ADD, 0, 0, 0, 0));
    vecs.push_back(mk("sub", 8'h21, 4'h0, 5, W_SUB, 0, 0, 0, 0));
    vecs.push_back(mk("and", 8'h22, 4'h0, 5, W_AND, 0, 0, 0, 0));
    vecs.push_back(mk("or",  8'h23, 4'h0, 5, W_OR, 0, 0, 0, 0));
    vecs.push_back(mk("inca", 8'h24, 4'h0, 5, W_INCA, 0, 0, 0, 0));
    vecs.push_back(mk("incb", 8'h25, 4'h0, 5, W_INCB, 0, 0, 0, 0));
    vecs.push_back(mk("deca", 8'h26, 4'h0, 5, W_DECA, 0, 0, 0, 0));
    vecs.push_back(mk("decb", 8'h27, 4'h0, 5, W_DECB, 0, 0, 0, 0));
    vecs.push_back(mk("bra", 8'h30, 4'h0, 7, W_MARPC, W_NONE, W_PCLD, 0, 0));
    vecs.push_back(mk("bnu_t", 8'h31, 4'h8, 7, W_MARPC, W_NONE, W_PCLD, 0, 0));
    vecs.push_back(mk("bnu_nt", 8'h31, 4'h7, 5, W_PCINC, 0, 0, 0, 0));
    vecs.push_back(mk("bnd_t", 8'h32, 4'h7, 7, W_MARPC, W_NONE, W_PCLD, 0, 0));
    vecs.push_back(mk("bzu_t", 8'h33, 4'h4, 7, W_MARPC, W_NONE, W_PCLD, 0, 0));
    vecs.push_back(mk("bzu_nt", 8'h33, 4'h0, 5, W_PCINC, 0, 0, 0, 0));
    vecs.push_back(mk("bzd_nt", 8'h34, 4'h4, 5, W_PCINC, 0, 0, 0, 0));
    vecs.push_back(mk("bvu_t", 8'h35, 4'h2, 7, W_MARPC, W_NONE, W_PCLD, 0, 0));
    vecs.push_back(mk("bvd_nt", 8'h36, 4'h2, 5, W_PCINC, 0, 0, 0, 0));
    vecs.push_back(mk("bcu_nt", 8'h37, 4'hE, 5, W_PCINC, 0, 0, 0, 0));
    vecs.push_back(mk("bcd_t", 8'h38, 4'hE, 7, W_MARPC, W_NONE, W_PCLD, 0, 0));
    vecs.push_back(mk("nop_ff", 8'hFF, 4'hF, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk("nop_00", 8'h00, 4'h0, 4, 0, 0, 0, 0, 0));

    // Reset held: F0 decode, then release at an F0 boundary.
    repeat (2) @(posedge clk);
    #1 push("reset_hold", W_MARPC);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid LDA_DIR at E7: must return to F0 on the next edge.
    ir = 8'h11; ccr_result = 4'h0;
    push_fetch("rst_mid");
    push("rst_mid.E4", W_MARPC); push("rst_mid.E5", W_PCINC);
    push("rst_mid.E6", W_MARMEM); push("rst_mid.E7", W_NONE);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 push("rst_mid.F0", W_MARPC);
    @(posedge clk);
    #1 reset = 1'b0;
    run_vec(vecs[6]);

    // CCR flips after D3 must not change a taken branch.
    ir = 8'h33; ccr_result = 4'h4;
    push_fetch("ccr_late");
    push("ccr_late.E4", W_MARPC); push("ccr_late.E5", W_NONE); push("ccr_late.E6", W_PCLD);
    repeat (4) @(posedge clk);
    #1 ccr_result = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    // CCR set to the taken value only before D3 and cleared in D3: not taken.
    ir = 8'h33; ccr_result = 4'h4;
    push_fetch("ccr_d3");
    push("ccr_d3.E4", W_PCINC);
    repeat (3) @(posedge clk);
    #1 ccr_result = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    run_vec(vecs[0]);

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
